// File: rtl/timeset_pkg.sv
// Shared encodings for the desk-clock time-set controller.
package timeset_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        SLOW  = 2'd2,
        FAST  = 2'd3
    } state_t;

    typedef enum logic {
        TGT_HOUR = 1'b0,
        TGT_MIN  = 1'b1
    } target_t;

    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_btn;
            sync2_r <= sync1_r;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r   <= '0;
            o_level <= 1'b0;
        end else if (sync2_r != o_level) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                o_level <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

endmodule

// File: rtl/timeset_ctrl.sv
// Time-set button controller: debounced hour/minute buttons drive one
// immediate increment, then slow and fast auto-repeat from the divider strobe.
module timeset_ctrl
    import timeset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int FAST_AFTER      = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_hour_btn,
    input  logic i_min_btn,
    input  logic i_timeset_stb,
    output logic o_div_en,
    output logic o_fast_set,
    output logic o_hour_inc,
    output logic o_min_inc,
    output logic o_setting
);

    localparam int RW = $clog2(FAST_AFTER + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(FAST_AFTER);

    logic          hour_level_s;
    logic          min_level_s;
    logic          tgt_level_s;
    logic [RW-1:0] rep_next_s;
    logic          hour_prev_r;
    logic          min_prev_r;
    state_t        state_r;
    target_t       tgt_r;
    logic [RW-1:0] rep_r;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hour_db (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_hour_btn),
        .o_level   (hour_level_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min_db (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_min_btn),
        .o_level   (min_level_s)
    );

    // Level of whichever button owns the current set, and the next repeat count.
    always_comb begin
        tgt_level_s = 1'b0;
        if (tgt_r == TGT_HOUR) begin
            tgt_level_s = hour_level_s;
        end else begin
            tgt_level_s = min_level_s;
        end
        rep_next_s = rep_r + RW'(1);
    end

    // Edge-history flops keep running while disabled so a held button needs a re-press.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hour_prev_r <= 1'b0;
            min_prev_r  <= 1'b0;
        end else begin
            hour_prev_r <= hour_level_s;
            min_prev_r  <= min_level_s;
        end
    end

    // Set FSM with registered outputs; release and disable take priority over strobes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= IDLE;
            tgt_r      <= TGT_HOUR;
            rep_r      <= '0;
            o_div_en   <= 1'b0;
            o_fast_set <= 1'b0;
            o_hour_inc <= 1'b0;
            o_min_inc  <= 1'b0;
            o_setting  <= 1'b0;
        end else begin
            o_hour_inc <= 1'b0;
            o_min_inc  <= 1'b0;
            if (!i_en) begin
                state_r    <= IDLE;
                rep_r      <= '0;
                o_div_en   <= 1'b0;
                o_fast_set <= 1'b0;
                o_setting  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        rep_r      <= '0;
                        o_div_en   <= 1'b0;
                        o_fast_set <= 1'b0;
                        if (rise(hour_level_s, hour_prev_r)) begin
                            state_r    <= PRESS;
                            tgt_r      <= TGT_HOUR;
                            o_hour_inc <= 1'b1;
                            o_setting  <= 1'b1;
                        end else if (!hour_level_s && rise(min_level_s, min_prev_r)) begin
                            state_r    <= PRESS;
                            tgt_r      <= TGT_MIN;
                            o_min_inc  <= 1'b1;
                            o_setting  <= 1'b1;
                        end else begin
                            o_setting  <= 1'b0;
                        end
                    end
                    PRESS: begin
                        if (!tgt_level_s) begin
                            state_r   <= IDLE;
                            o_setting <= 1'b0;
                        end else begin
                            state_r   <= SLOW;
                            o_div_en  <= 1'b1;
                        end
                    end
                    SLOW: begin
                        if (!tgt_level_s) begin
                            state_r    <= IDLE;
                            rep_r      <= '0;
                            o_div_en   <= 1'b0;
                            o_fast_set <= 1'b0;
                            o_setting  <= 1'b0;
                        end else if (i_timeset_stb) begin
                            o_hour_inc <= (tgt_r == TGT_HOUR);
                            o_min_inc  <= (tgt_r == TGT_MIN);
                            rep_r      <= rep_next_s;
                            if (rep_next_s == REP_MAX) begin
                                state_r    <= FAST;
                                o_fast_set <= 1'b1;
                            end else begin
                                state_r    <= SLOW;
                            end
                        end else begin
                            state_r <= SLOW;
                        end
                    end
                    FAST: begin
                        if (!tgt_level_s) begin
                            state_r    <= IDLE;
                            rep_r      <= '0;
                            o_div_en   <= 1'b0;
                            o_fast_set <= 1'b0;
                            o_setting  <= 1'b0;
                        end else if (i_timeset_stb) begin
                            o_hour_inc <= (tgt_r == TGT_HOUR);
                            o_min_inc  <= (tgt_r == TGT_MIN);
                        end else begin
                            state_r <= FAST;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        rep_r      <= '0;
                        o_div_en   <= 1'b0;
                        o_fast_set <= 1'b0;
                        o_setting  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timeset_ctrl.sv
// Directed self-checking bench for timeset_ctrl (DEBOUNCE_CYCLES=4, FAST_AFTER=2).
module tb_timeset_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic hour_btn = 1'b0;
    logic min_btn = 1'b0;
    logic stb = 1'b0;
    logic o_div_en, o_fast_set, o_hour_inc, o_min_inc, o_setting;
    logic [4:0] outs;

    int checks = 0;
    int errors = 0;
    int hour_cnt = 0;
    int min_cnt = 0;
    int both_cnt = 0;
    int set_cnt = 0;
    int h0, m0, s0;

    assign outs = {o_div_en, o_fast_set, o_hour_inc, o_min_inc, o_setting};

    timeset_ctrl #(.DEBOUNCE_CYCLES(4), .FAST_AFTER(2)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_en          (en),
        .i_hour_btn    (hour_btn),
        .i_min_btn     (min_btn),
        .i_timeset_stb (stb),
        .o_div_en      (o_div_en),
        .o_fast_set    (o_fast_set),
        .o_hour_inc    (o_hour_inc),
        .o_min_inc     (o_min_inc),
        .o_setting     (o_setting)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_hour_inc) hour_cnt++;
        if (o_min_inc) min_cnt++;
        if (o_hour_inc && o_min_inc) both_cnt++;
        if (o_setting) set_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, 5'b0); end
        rst_n = 1'b1;
        step(3);
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL post_reset_outs: got %b expected %b", outs, 5'b0); end
    endtask

    task automatic test_single_press();
        h0 = hour_cnt;
        hour_btn = 1'b1;
        step(6);
        checks++; if ({o_hour_inc, o_setting} !== 2'b00) begin errors++; $display("FAIL press_early: got %b expected %b", {o_hour_inc, o_setting}, 2'b00); end
        step(1);
        checks++; if ({o_hour_inc, o_min_inc, o_setting} !== 3'b101) begin errors++; $display("FAIL press_pulse: got %b expected %b", {o_hour_inc, o_min_inc, o_setting}, 3'b101); end
        step(1);
        checks++; if (outs !== 5'b10001) begin errors++; $display("FAIL press_slow: got %b expected %b", outs, 5'b10001); end
        step(12);
        hour_btn = 1'b0;
        step(6);
        checks++; if (o_setting !== 1'b1) begin errors++; $display("FAIL release_hold: got %b expected %b", o_setting, 1'b1); end
        step(1);
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL release_idle: got %b expected %b", outs, 5'b0); end
        checks++; if (hour_cnt - h0 !== 1) begin errors++; $display("FAIL press_count: got %0d expected %0d", hour_cnt - h0, 1); end
    endtask

    task automatic test_bounce();
        m0 = min_cnt;
        s0 = set_cnt;
        for (int i = 0; i < 10; i++) begin
            min_btn = (i % 2 == 0);
            step(2);
        end
        min_btn = 1'b0;
        step(10);
        checks++; if (min_cnt - m0 !== 0) begin errors++; $display("FAIL bounce_inc: got %0d expected %0d", min_cnt - m0, 0); end
        checks++; if (set_cnt - s0 !== 0) begin errors++; $display("FAIL bounce_setting: got %0d expected %0d", set_cnt - s0, 0); end
    endtask

    task automatic test_auto_repeat();
        m0 = min_cnt;
        min_btn = 1'b1;
        step(7);
        checks++; if (o_min_inc !== 1'b1) begin errors++; $display("FAIL rep_first: got %b expected %b", o_min_inc, 1'b1); end
        for (int k = 0; k < 4; k++) begin
            step(9);
            checks++; if ({o_div_en, o_fast_set} !== {1'b1, (k >= 2)}) begin errors++; $display("FAIL rep_wait%0d: got %b expected %b", k, {o_div_en, o_fast_set}, {1'b1, (k >= 2)}); end
            stb = 1'b1;
            step(1);
            stb = 1'b0;
            checks++; if ({o_div_en, o_fast_set, o_hour_inc, o_min_inc} !== {1'b1, (k >= 1), 1'b0, 1'b1}) begin
                errors++; $display("FAIL rep_strobe%0d: got %b expected %b", k, {o_div_en, o_fast_set, o_hour_inc, o_min_inc}, {1'b1, (k >= 1), 1'b0, 1'b1});
            end
        end
        min_btn = 1'b0;
        step(7);
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL rep_release: got %b expected %b", outs, 5'b0); end
        checks++; if (min_cnt - m0 !== 5) begin errors++; $display("FAIL rep_count: got %0d expected %0d", min_cnt - m0, 5); end
    endtask

    task automatic test_priority();
        h0 = hour_cnt;
        m0 = min_cnt;
        hour_btn = 1'b1;
        min_btn = 1'b1;
        step(7);
        checks++; if ({o_hour_inc, o_min_inc} !== 2'b10) begin errors++; $display("FAIL prio_pulse: got %b expected %b", {o_hour_inc, o_min_inc}, 2'b10); end
        step(5);
        hour_btn = 1'b0;
        step(7);
        checks++; if (o_setting !== 1'b0) begin errors++; $display("FAIL prio_release: got %b expected %b", o_setting, 1'b0); end
        step(10);
        checks++; if (min_cnt - m0 !== 0) begin errors++; $display("FAIL prio_no_min: got %0d expected %0d", min_cnt - m0, 0); end
        checks++; if (hour_cnt - h0 !== 1) begin errors++; $display("FAIL prio_hour_count: got %0d expected %0d", hour_cnt - h0, 1); end
        min_btn = 1'b0;
        step(8);
        min_btn = 1'b1;
        step(7);
        checks++; if ({o_hour_inc, o_min_inc} !== 2'b01) begin errors++; $display("FAIL prio_repress: got %b expected %b", {o_hour_inc, o_min_inc}, 2'b01); end
        min_btn = 1'b0;
        step(8);
    endtask

    task automatic test_enable();
        h0 = hour_cnt;
        hour_btn = 1'b1;
        step(9);
        en = 1'b0;
        stb = 1'b1;
        step(1);
        stb = 1'b0;
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL en_drop: got %b expected %b", outs, 5'b0); end
        checks++; if (hour_cnt - h0 !== 1) begin errors++; $display("FAIL en_drop_count: got %0d expected %0d", hour_cnt - h0, 1); end
        step(3);
        en = 1'b1;
        step(10);
        checks++; if (o_setting !== 1'b0 || hour_cnt - h0 !== 1) begin errors++; $display("FAIL en_held: got %b/%0d expected %b/%0d", o_setting, hour_cnt - h0, 1'b0, 1); end
        hour_btn = 1'b0;
        step(8);
        hour_btn = 1'b1;
        step(7);
        checks++; if (o_hour_inc !== 1'b1) begin errors++; $display("FAIL en_repress: got %b expected %b", o_hour_inc, 1'b1); end
        hour_btn = 1'b0;
        step(8);
    endtask

    task automatic test_reset_mid_fast();
        hour_btn = 1'b1;
        step(8);
        stb = 1'b1;
        step(1);
        stb = 1'b0;
        step(3);
        stb = 1'b1;
        step(1);
        stb = 1'b0;
        checks++; if ({o_fast_set, o_hour_inc} !== 2'b11) begin errors++; $display("FAIL fast_entry: got %b expected %b", {o_fast_set, o_hour_inc}, 2'b11); end
        step(2);
        #2;
        rst_n = 1'b0;
        hour_btn = 1'b0;
        #1;
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL async_reset: got %b expected %b", outs, 5'b0); end
        step(3);
        rst_n = 1'b1;
        step(10);
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL reset_idle: got %b expected %b", outs, 5'b0); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_priority();
        test_enable();
        test_reset_mid_fast();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL simultaneous_inc: got %0d expected %0d", both_cnt, 0); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timeset_ctrl.md
# timeset_ctrl

Time-set button controller for the desk clock. It synchronizes and debounces the raw hour-set and minute-set buttons and drives the enable and fast-select inputs of the timeset strobe divider. It turns the returned strobes into one-cycle hour/minute increment pulses for the clock counter chain. A press gives one immediate increment, then slow auto-repeat, then fast auto-repeat after a fixed number of slow repeats.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250_000: consecutive stable sys-clock cycles required to accept a button level change (5 ms at 50 MHz); must be ≥2.
- FAST_AFTER, 4: number of slow-repeat increments before switching to fast repeat; must be ≥1.

Ports:
- i_clk  input  1  system clock (~50 MHz)
- i_reset_n  input  1  asynchronous, active-low reset
- i_en  input  1  block enable; low forces IDLE
- i_hour_btn  input  1  raw hour-set button, active high, asynchronous to i_clk
- i_min_btn  input  1  raw minute-set button, active high, asynchronous to i_clk
- i_timeset_stb  input  1  one-cycle strobe from the timeset divider
- o_div_en  output  1  enable to the timeset divider
- o_fast_set  output  1  fast-select to the timeset divider (1 = fast)
- o_hour_inc  output  1  one-cycle hour increment pulse
- o_min_inc  output  1  one-cycle minute increment pulse
- o_setting  output  1  high while any set is active; the seconds counter holds at 0

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. Debounced reset value is 0.
- Active button selection: hour has priority. The minute button is considered only when the debounced hour level is 0 in IDLE. Once a set starts, only the selected button's release ends it.
- FSM states:
  - IDLE: all outputs 0. On rising debounced level of the selected button → PRESS, latching the target (hour/min).
  - PRESS: emits one increment pulse on the target for exactly one cycle → SLOW.
  - SLOW: o_div_en=1, o_fast_set=0. Each i_timeset_stb emits one target increment and increments the repeat counter. When the counter reaches FAST_AFTER → FAST. The transition happens on the same edge that registers the FAST_AFTER-th increment.
  - FAST: o_div_en=1, o_fast_set=1. Each i_timeset_stb emits one target increment.
- Release: debounced level of the target falls in PRESS, SLOW or FAST → IDLE on the next edge. The repeat counter clears and no further increments occur. A strobe arriving in that same cycle is ignored.
- i_timeset_stb in IDLE or PRESS is ignored.
- i_en=0: FSM forced to IDLE and all outputs driven 0 on the next edge. Synchronizers and debouncers keep running, so a button still held when i_en returns does not start a set until it is released and pressed again (rising edge required).
- o_setting = 1 in PRESS, SLOW, FAST.
- The repeat counter has width $clog2(FAST_AFTER+1) and saturates at FAST_AFTER. The debounce counter has width $clog2(DEBOUNCE_CYCLES+1).

## Timing
- Reset: all outputs 0, FSM IDLE, debounced levels 0, counters 0, sync flops 0.
- All outputs are registered.
- Press latency: a button rising at the sync input appears synchronized after 2 cycles. Debounced goes high DEBOUNCE_CYCLES cycles later. The FSM enters PRESS on the next edge. The increment pulse is high during PRESS (1 cycle).
- Repeat latency: the increment pulse is high the cycle after i_timeset_stb is sampled high.
- o_hour_inc and o_min_inc are never high simultaneously, and are never high for 2 consecutive cycles except when consecutive strobes arrive.
- Asynchronous reset mid-set: immediate return to IDLE, outputs 0 with no completing pulse.

## Structure
- Sub-module: button_debounce (parameter DEBOUNCE_CYCLES; contains the 2-FF synchronizer and stable counter; ports i_clk, i_reset_n, i_btn, o_level). It is instantiated twice.
- Shared package timeset_pkg: FSM state encoding (IDLE, PRESS, SLOW, FAST) and target encoding (TGT_HOUR, TGT_MIN).
- FSM, target latch and repeat counter live in the top module.

## Test plan
Use DEBOUNCE_CYCLES=4 and FAST_AFTER=2 unless stated.
- Reset: assert i_reset_n=0 mid-FAST → all outputs 0 immediately; FSM IDLE after release.
- Single press: hour pressed 20 cycles and released, with no strobes → exactly one o_hour_inc pulse, 7 cycles after the raw edge; o_setting high from that cycle until 7 cycles after the raw release.
- Bounce: minute input toggles every 2 cycles for 20 cycles, then stays low → no o_min_inc, o_setting stays 0.
- Auto-repeat: hold minute and inject strobes every 10 cycles → o_min_inc count is 1 + number of strobes; o_fast_set=0 until the 2nd strobe increment, 1 after it; o_div_en=1 throughout the hold.
- Priority/simultaneity: both buttons rise together → only o_hour_inc pulses. Then release hour while minute is held → IDLE, no o_min_inc until minute is re-pressed.
- Enable: i_en dropped during SLOW with a strobe on the same cycle → no increment, outputs 0 next cycle. Raise i_en with the button held → no increment until release and re-press.
